// File: rtl/announce_sequencer.sv
// Drives the audio clip player through one colour report: "red", <red count>,
// "green", <green count>, with a silence gap after every clip.
module announce_sequencer #(
  parameter int GAP_CYCLES     = 800000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] redCountIn,
  input  logic [3:0] greenCountIn,
  input  logic       sampleDone,
  output logic [3:0] redCount,
  output logic [3:0] greenCount,
  output logic       redAudioRequest,
  output logic       redCountAudioRequest,
  output logic       greenAudioRequest,
  output logic       greenCountAudioRequest,
  output logic       sampleDoneAck,
  output logic       busy,
  output logic       done,
  output logic       timeoutErr
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_GAP} state_t;

  state_t          r_state;
  logic [1:0]      r_clip;
  logic [GW-1:0]   r_gap;
  logic [TW-1:0]   r_timer;
  logic [3:0]      r_req;
  logic            r_ack;
  logic            r_busy;
  logic            r_done;
  logic            r_timeout_err;
  logic [3:0]      r_red;
  logic [3:0]      r_green;
  logic            r_pending;
  logic [3:0]      r_pend_red;
  logic [3:0]      r_pend_green;

  logic            w_pend_any;
  logic [3:0]      w_pend_red;
  logic [3:0]      w_pend_green;
  logic [3:0]      w_sat_red;
  logic [3:0]      w_sat_green;

  // The player only has number clips 0..5.
  function automatic logic [3:0] sat5(input logic [3:0] c);
    return (c > 4'd5) ? 4'd5 : c;
  endfunction

  assign w_sat_red    = sat5(redCountIn);
  assign w_sat_green  = sat5(greenCountIn);
  // A start landing on the final gap cycle still counts as queued.
  assign w_pend_any   = r_pending | start;
  assign w_pend_red   = start ? w_sat_red   : r_pend_red;
  assign w_pend_green = start ? w_sat_green : r_pend_green;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_clip        <= 2'd0;
      r_gap         <= '0;
      r_timer       <= '0;
      r_req         <= 4'd0;
      r_ack         <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_red         <= 4'd0;
      r_green       <= 4'd0;
      r_pending     <= 1'b0;
      r_pend_red    <= 4'd0;
      r_pend_green  <= 4'd0;
    end else begin
      r_req  <= 4'd0;
      r_ack  <= 1'b0;
      r_done <= 1'b0;

      if (start && r_state != S_IDLE) begin
        r_pending    <= 1'b1;
        r_pend_red   <= w_sat_red;
        r_pend_green <= w_sat_green;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_red         <= w_sat_red;
            r_green       <= w_sat_green;
            r_busy        <= 1'b1;
            r_clip        <= 2'd0;
            r_timeout_err <= 1'b0;
            r_state       <= S_REQ;
          end
        end
        S_REQ: begin
          // A still-high sampleDone belongs to the previous clip.
          if (!sampleDone) begin
            r_req[r_clip] <= 1'b1;
            r_timer       <= '0;
            r_state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (sampleDone) begin
            r_ack   <= 1'b1;
            r_gap   <= '0;
            r_state <= S_GAP;
          end else if (r_timer == TO_LAST) begin
            r_timeout_err <= 1'b1;
            r_gap         <= '0;
            r_state       <= S_GAP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            if (r_clip != 2'd3) begin
              r_clip  <= r_clip + 2'd1;
              r_state <= S_REQ;
            end else begin
              r_done <= 1'b1;
              if (w_pend_any) begin
                r_red     <= w_pend_red;
                r_green   <= w_pend_green;
                r_pending <= 1'b0;
                r_clip    <= 2'd0;
                r_state   <= S_REQ;
              end else begin
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            end
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign redCount               = r_red;
  assign greenCount             = r_green;
  assign redAudioRequest        = r_req[0];
  assign redCountAudioRequest   = r_req[1];
  assign greenAudioRequest      = r_req[2];
  assign greenCountAudioRequest = r_req[3];
  assign sampleDoneAck          = r_ack;
  assign busy                   = r_busy;
  assign done                   = r_done;
  assign timeoutErr             = r_timeout_err;

endmodule

// File: tb/tb_announce_sequencer.sv
// Scoreboard bench for announce_sequencer: expected clip requests are queued
// at each start and popped as the DUT issues them, with a small player model.
module tb_announce_sequencer;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] redCountIn = 4'd0;
  logic [3:0] greenCountIn = 4'd0;
  logic       sampleDone = 1'b0;
  logic [3:0] redCount, greenCount;
  logic       redAudioRequest, redCountAudioRequest;
  logic       greenAudioRequest, greenCountAudioRequest;
  logic       sampleDoneAck, busy, done, timeoutErr;

  announce_sequencer #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(20)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start),
    .redCountIn(redCountIn), .greenCountIn(greenCountIn),
    .sampleDone(sampleDone), .redCount(redCount), .greenCount(greenCount),
    .redAudioRequest(redAudioRequest), .redCountAudioRequest(redCountAudioRequest),
    .greenAudioRequest(greenAudioRequest), .greenCountAudioRequest(greenCountAudioRequest),
    .sampleDoneAck(sampleDoneAck), .busy(busy), .done(done), .timeoutErr(timeoutErr)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int         kind;
    logic [3:0] red;
    logic [3:0] green;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   req_count = 0;
  int   ack_count = 0;
  int   done_count = 0;
  int   req_cyc[4];
  int   te_cyc = -1;
  int   start_cyc = 0;
  int   ignore_kind = -1;
  logic force_sd = 1'b0;
  logic prev_any_req = 1'b0;
  logic prev_te = 1'b0;

  always @(posedge CLOCK_50) cyc++;

  // Player model: raises sampleDone 5 cycles after a request, drops it on ack.
  int   play_cnt = 0;
  logic play_sd = 1'b0;
  always @(negedge CLOCK_50) begin
    if (reset) begin
      play_cnt = 0;
      play_sd  = 1'b0;
    end else begin
      if (sampleDoneAck) play_sd = 1'b0;
      if (play_cnt > 0) begin
        play_cnt--;
        if (play_cnt == 0) play_sd = 1'b1;
      end
      if (redAudioRequest && ignore_kind != 0) play_cnt = 5;
      if (redCountAudioRequest && ignore_kind != 1) play_cnt = 5;
      if (greenAudioRequest && ignore_kind != 2) play_cnt = 5;
      if (greenCountAudioRequest && ignore_kind != 3) play_cnt = 5;
    end
    sampleDone = play_sd | force_sd;
  end

  // Monitor: pops the scoreboard on every request.
  always @(negedge CLOCK_50) begin
    int   nreq;
    int   kind;
    exp_t e;
    if (!reset) begin
      nreq = int'(redAudioRequest) + int'(redCountAudioRequest)
           + int'(greenAudioRequest) + int'(greenCountAudioRequest);
      kind = redAudioRequest ? 0 : redCountAudioRequest ? 1 : greenAudioRequest ? 2 : 3;
      if (nreq > 0) begin
        checks++;
        if (nreq != 1 || sampleDoneAck || prev_any_req) begin
          errors++;
          $display("FAIL req_exclusive: cyc=%0d nreq=%0d ack=%b prev_req=%b required nreq=1 ack=0 prev_req=0",
                   cyc, nreq, sampleDoneAck, prev_any_req);
        end
        req_count++;
        req_cyc[kind] = cyc;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_req: cyc=%0d kind=%0d with empty scoreboard", cyc, kind);
        end else begin
          e = sb.pop_front();
          if (kind != e.kind || redCount !== e.red || greenCount !== e.green) begin
            errors++;
            $display("FAIL req_order: cyc=%0d got kind=%0d red=%0d green=%0d required kind=%0d red=%0d green=%0d",
                     cyc, kind, redCount, greenCount, e.kind, e.red, e.green);
          end else begin
            $display("req cyc=%0d kind=%0d red=%0d green=%0d", cyc, kind, redCount, greenCount);
          end
        end
      end
      prev_any_req = (nreq > 0);
      if (sampleDoneAck) ack_count++;
      if (done) done_count++;
      if (timeoutErr && !prev_te) te_cyc = cyc;
      prev_te = timeoutErr;
    end else begin
      prev_any_req = 1'b0;
      prev_te      = 1'b0;
    end
  end

  task automatic tick();
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic do_start(input int r, input int g);
    logic [3:0] rs, gs;
    rs = (r > 5) ? 4'd5 : 4'(r);
    gs = (g > 5) ? 4'd5 : 4'(g);
    for (int k = 0; k < 4; k++) sb.push_back('{k, rs, gs});
    start = 1'b1;
    redCountIn = 4'(r);
    greenCountIn = 4'(g);
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_count < target && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (done_count < target) begin
      errors++;
      $display("FAIL wait_done: done_count=%0d required %0d within %0d cycles", done_count, target, budget);
    end
  endtask

  task automatic wait_req(input int target, input int budget);
    int n;
    n = 0;
    while (req_count < target && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (req_count < target) begin
      errors++;
      $display("FAIL wait_req: req_count=%0d required %0d within %0d cycles", req_count, target, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({redCount, greenCount, redAudioRequest, redCountAudioRequest, greenAudioRequest,
         greenCountAudioRequest, sampleDoneAck, busy, done, timeoutErr} !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: red=%0d green=%0d busy=%b done=%b te=%b required all 0",
               redCount, greenCount, busy, done, timeoutErr);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int a0, d0;
    a0 = ack_count;
    d0 = done_count;
    do_start(2, 3);
    wait_done(d0 + 1, 200);
    checks++;
    if (req_cyc[0] != start_cyc + 2) begin
      errors++;
      $display("FAIL start_latency: red request cyc=%0d required %0d", req_cyc[0], start_cyc + 2);
    end
    checks++;
    if (ack_count - a0 != 4) begin
      errors++;
      $display("FAIL ack_count: got %0d required 4", ack_count - a0);
    end
    checks++;
    if (timeoutErr !== 1'b0) begin
      errors++;
      $display("FAIL basic_timeout: timeoutErr=%b required 0", timeoutErr);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || done_count - d0 != 1) begin
      errors++;
      $display("FAIL basic_end: busy=%b done=%b dones=%0d required busy=0 done=0 dones=1",
               busy, done, done_count - d0);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL basic_leftover: %0d expected requests never seen, required 0", sb.size());
    end
  endtask

  task automatic test_saturate();
    int d0;
    d0 = done_count;
    do_start(9, 15);
    checks++;
    if (redCount !== 4'd5 || greenCount !== 4'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL saturate: red=%0d green=%0d busy=%b required 5 5 1", redCount, greenCount, busy);
    end
    wait_done(d0 + 1, 200);
    tick();
  endtask

  task automatic test_timeout();
    int a0, d0;
    a0 = ack_count;
    d0 = done_count;
    te_cyc = -1;
    ignore_kind = 1;
    do_start(1, 2);
    wait_done(d0 + 1, 300);
    ignore_kind = -1;
    checks++;
    if (te_cyc != req_cyc[1] + 20) begin
      errors++;
      $display("FAIL timeout_time: timeoutErr rose cyc=%0d required %0d", te_cyc, req_cyc[1] + 20);
    end
    checks++;
    if (req_cyc[2] != req_cyc[1] + 25) begin
      errors++;
      $display("FAIL timeout_resume: green request cyc=%0d required %0d", req_cyc[2], req_cyc[1] + 25);
    end
    checks++;
    if (ack_count - a0 != 3 || timeoutErr !== 1'b1) begin
      errors++;
      $display("FAIL timeout_acks: acks=%0d te=%b required acks=3 te=1", ack_count - a0, timeoutErr);
    end
    tick();
  endtask

  task automatic test_stale_done();
    int r0, d0;
    d0 = done_count;
    force_sd = 1'b1;
    tick();
    do_start(0, 0);
    r0 = req_count;
    checks++;
    if (timeoutErr !== 1'b0) begin
      errors++;
      $display("FAIL start_clears_te: timeoutErr=%b required 0", timeoutErr);
    end
    repeat (12) tick();
    checks++;
    if (req_count != r0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stale_hold: requests=%0d busy=%b required 0 1", req_count - r0, busy);
    end
    force_sd = 1'b0;
    wait_done(d0 + 1, 200);
    checks++;
    if (req_count - r0 != 4) begin
      errors++;
      $display("FAIL stale_requests: got %0d required 4", req_count - r0);
    end
    tick();
  endtask

  task automatic test_pending();
    int   r0, d0, n;
    logic busy_dropped;
    r0 = req_count;
    d0 = done_count;
    busy_dropped = 1'b0;
    do_start(1, 1);
    wait_req(r0 + 2, 60);
    do_start(4, 0);
    n = 0;
    while (done_count < d0 + 1 && n < 200) begin
      if (busy !== 1'b1) busy_dropped = 1'b1;
      tick();
      n++;
    end
    checks++;
    if (done_count != d0 + 1 || redCount !== 4'd4 || greenCount !== 4'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pending_load: dones=%0d red=%0d green=%0d busy=%b required 1 4 0 1",
               done_count - d0, redCount, greenCount, busy);
    end
    while (done_count < d0 + 2 && n < 400) begin
      if (busy !== 1'b1) busy_dropped = 1'b1;
      tick();
      n++;
    end
    checks++;
    if (busy_dropped || done_count != d0 + 2) begin
      errors++;
      $display("FAIL pending_busy: busy_dropped=%b dones=%0d required 0 2", busy_dropped, done_count - d0);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int r0;
    r0 = req_count;
    do_start(1, 2);
    wait_req(r0 + 2, 60);
    do_start(3, 3);
    wait_req(r0 + 3, 60);
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({redCount, greenCount, redAudioRequest, redCountAudioRequest, greenAudioRequest,
         greenCountAudioRequest, sampleDoneAck, busy, done, timeoutErr} !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid: red=%0d green=%0d busy=%b done=%b te=%b required all 0",
               redCount, greenCount, busy, done, timeoutErr);
    end
    reset = 1'b0;
    sb.delete();
    r0 = req_count;
    repeat (40) tick();
    checks++;
    if (req_count != r0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiet: requests=%0d busy=%b required 0 0", req_count - r0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_timeout();
    test_stale_done();
    test_pending();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
